// File: rtl/msg_stream_arbiter.sv
// msg_stream_arbiter: packet-locked round-robin arbiter forwarding one AXI-Stream source at a time.
// Optional beat limit with truncation/drain enabled by ARB_BEAT_LIMIT_EN.
module msg_stream_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_BYTES  = 8,
  parameter int TKEEP_WIDTH = 8,
  parameter int MAX_BEATS   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  output logic [NUM_SRC-1:0]                s_tready,
  input  logic [NUM_SRC-1:0]                s_tlast,
  input  logic [NUM_SRC-1:0]                s_tuser,
  input  logic [NUM_SRC*TKEEP_WIDTH-1:0]    s_tkeep,
  input  logic [NUM_SRC*8*DATA_BYTES-1:0]   s_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic                              m_tuser,
  output logic [TKEEP_WIDTH-1:0]            m_tkeep,
  output logic [8*DATA_BYTES-1:0]           m_tdata,
  output logic [NUM_SRC-1:0]                grant,
  output logic                              busy
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int PW = $clog2(NUM_SRC);
`ifdef ARB_BEAT_LIMIT_EN
  localparam int CW = $clog2(MAX_BEATS + 1);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic {IDLE, XFER} state_t;
`endif
  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, g_q, g_d, pick, nxt;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic mv_q, mv_d, ml_q, ml_d, mu_q, mu_d;
  logic [TKEEP_WIDTH-1:0] mk_q, mk_d;
  logic [DW-1:0] md_q, md_d;
  logic found, ready, acc, sl, su;
  logic [TKEEP_WIDTH-1:0] sk;
  logic [DW-1:0] sd;
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && s_tvalid[(int'(rr_q) + i) % NUM_SRC]) begin
        found = 1'b1;
        pick  = PW'((int'(rr_q) + i) % NUM_SRC);
      end
    end
  end
  assign sl = s_tlast[g_q];
  assign su = s_tuser[g_q];
  assign sk = s_tkeep[g_q*TKEEP_WIDTH +: TKEEP_WIDTH];
  assign sd = s_tdata[g_q*DW +: DW];
`ifdef ARB_BEAT_LIMIT_EN
  assign ready = (state_q == XFER) ? (!mv_q || m_tready) : (state_q == DRAIN);
`else
  assign ready = (state_q == XFER) && (!mv_q || m_tready);
`endif
  assign s_tready = ready ? grant_q : '0;
  assign acc = s_tvalid[g_q] && ready;
  assign nxt = (g_q == PW'(NUM_SRC - 1)) ? '0 : g_q + 1'b1;
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    grant_d = grant_q;
    mv_d    = mv_q && !m_tready;
    ml_d    = ml_q;
    mu_d    = mu_q;
    mk_d    = mk_q;
    md_d    = md_q;
`ifdef ARB_BEAT_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    if (state_q == IDLE) begin
      if (found) begin
        state_d = XFER;
        g_d     = pick;
        grant_d = NUM_SRC'(1) << pick;
      end
    end else if (acc) begin
      if (state_q == XFER) begin
        mv_d = 1'b1;
        ml_d = sl;
        mu_d = su;
        mk_d = sk;
        md_d = sd;
`ifdef ARB_BEAT_LIMIT_EN
        cnt_d = cnt_q + 1'b1;
        if (!sl && cnt_q == CW'(MAX_BEATS - 1)) begin
          ml_d    = 1'b1;
          mu_d    = 1'b1;
          state_d = DRAIN;
          cnt_d   = '0;
        end
`endif
      end
      if (sl) begin
        state_d = IDLE;
        rr_d    = nxt;
        grant_d = '0;
`ifdef ARB_BEAT_LIMIT_EN
        cnt_d   = '0;
`endif
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      grant_q <= '0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
      mu_q    <= 1'b0;
      mk_q    <= '0;
      md_q    <= '0;
`ifdef ARB_BEAT_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
      mu_q    <= mu_d;
      mk_q    <= mk_d;
      md_q    <= md_d;
`ifdef ARB_BEAT_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign m_tvalid = mv_q;
  assign m_tlast  = ml_q;
  assign m_tuser  = mu_q;
  assign m_tkeep  = mk_q;
  assign m_tdata  = md_q;
  assign grant    = grant_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_msg_stream_arbiter.sv
// tb_msg_stream_arbiter: directed and randomized checks against a message-level round-robin model.
module tb_msg_stream_arbiter;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int DW = 64;
  localparam int MB = 4;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1, m_tready = 1'b0;
  logic [N-1:0] s_tvalid = '0, s_tready, s_tlast = '0, s_tuser = '0, grant;
  logic [N*KW-1:0] s_tkeep = '0;
  logic [N*DW-1:0] s_tdata = '0;
  logic m_tvalid, m_tlast, m_tuser, busy;
  logic [KW-1:0] m_tkeep;
  logic [DW-1:0] m_tdata;
  msg_stream_arbiter #(.NUM_SRC(N), .DATA_BYTES(8), .TKEEP_WIDTH(KW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tkeep(s_tkeep), .s_tdata(s_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tkeep(m_tkeep),
    .m_tdata(m_tdata), .grant(grant), .busy(busy)
  );
  always #5 clk = ~clk;
  beat_t srcq[N][$];
  int lenq[N][$];
  int curlen[N];
  beat_t expq[$], olog[$];
  int ocyc[$];
  logic [N-1:0] glog[$], tlog[$];
  logic blog[$];
  bit pat[$];
  int pass_n = 0, tot_n = 0;

  task automatic add_beat(input int k, input logic [DW-1:0] d, input logic [KW-1:0] kp,
                          input logic l, input logic u);
    beat_t b;
    b.d = d; b.k = kp; b.l = l; b.u = u;
    srcq[k].push_back(b);
    curlen[k]++;
    if (l) begin
      lenq[k].push_back(curlen[k]);
      curlen[k] = 0;
    end
  endtask

  task automatic add_rand_msg(input int k, input int len);
    for (int j = 0; j < len; j++)
      add_beat(k, {$urandom, $urandom}, KW'($urandom), j == len - 1, 1'($urandom));
  endtask

  // Whole-message round robin: every queued source is continuously valid, so the
  // output is each chosen source's complete message, pointer moving past the winner.
  task automatic build_expected();
    int ptr, k, len, kk;
    int pos[N], mi[N];
    bit found;
    beat_t b;
    ptr = 0;
    for (int i = 0; i < N; i++) begin pos[i] = 0; mi[i] = 0; end
    expq.delete();
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      k = 0;
      for (int i = 0; i < N; i++) begin
        kk = (ptr + i) % N;
        if (!found && mi[kk] < lenq[kk].size()) begin found = 1'b1; k = kk; end
      end
      if (found) begin
        len = lenq[k][mi[k]];
        for (int j = 0; j < len; j++) begin
          b = srcq[k][pos[k] + j];
`ifdef ARB_BEAT_LIMIT_EN
          if (len > MB && j == MB - 1) begin b.l = 1'b1; b.u = 1'b1; end
          if (len <= MB || j < MB) expq.push_back(b);
`else
          expq.push_back(b);
`endif
        end
        pos[k] += len;
        mi[k]++;
        ptr = (k + 1) % N;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_tvalid[k] = srcq[k].size() > 0;
      if (srcq[k].size() > 0) begin
        s_tdata[k*DW +: DW] = srcq[k][0].d;
        s_tkeep[k*KW +: KW] = srcq[k][0].k;
        s_tlast[k] = srcq[k][0].l;
        s_tuser[k] = srcq[k][0].u;
      end else begin
        s_tdata[k*DW +: DW] = '0;
        s_tkeep[k*KW +: KW] = '0;
        s_tlast[k] = 1'b0;
        s_tuser[k] = 1'b0;
      end
    end
  endtask

  function automatic logic rdy(input int c, input bit rnd);
    if (c < pat.size()) return pat[c];
    return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    m_tready = 1'b0;
    for (int k = 0; k < N; k++) begin srcq[k].delete(); lenq[k].delete(); curlen[k] = 0; end
    pat.delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int budget, input bit rnd, input bit partial);
    int c;
    bit done;
    logic [N-1:0] hs;
    beat_t ob, e;
    c = 0;
    done = 1'b0;
    olog.delete(); ocyc.delete(); glog.delete(); tlog.delete(); blog.delete();
    m_tready = rdy(0, rnd);
    drive();
    while (c < budget && !done) begin
      @(negedge clk);
      glog.push_back(grant);
      tlog.push_back(s_tready);
      blog.push_back(busy);
      tot_n++;
      if ($onehot0(s_tready) && $onehot0(grant) && (s_tready & ~grant) == '0) pass_n++;
      else $display("FAIL ready_onehot cyc %0d s_tready=%b grant=%b, required one-hot0 within grant", c, s_tready, grant);
      hs = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
        ob.d = m_tdata; ob.k = m_tkeep; ob.l = m_tlast; ob.u = m_tuser;
        olog.push_back(ob);
        ocyc.push_back(c);
        tot_n++;
        if (expq.size() == 0) $display("FAIL extra_beat cyc %0d got %h, required no beat", c, ob);
        else begin
          e = expq.pop_front();
          if (ob === e) pass_n++;
          else $display("FAIL beat cyc %0d got %h required %h", c, ob, e);
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (hs[k]) void'(srcq[k].pop_front());
      c++;
      m_tready = rdy(c, rnd);
      drive();
      done = expq.size() == 0;
      for (int k = 0; k < N; k++) if (srcq[k].size() > 0) done = 1'b0;
    end
    if (!partial) begin
      tot_n++;
      if (done) pass_n++;
      else $display("FAIL timeout after %0d cycles, %0d beats outstanding, required 0", c, expq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tot_n++;
    if ({m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata, grant, busy, s_tready} === '0) pass_n++;
    else $display("FAIL reset_outputs got v%b l%b u%b k%h d%h g%b b%b r%b required all 0",
                  m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata, grant, busy, s_tready);
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    add_beat(0, 64'h1111111111111111, 8'hFF, 1'b0, 1'b0);
    add_beat(0, 64'h2222222222222222, 8'hFF, 1'b0, 1'b0);
    add_beat(0, 64'h3333333333333333, 8'hFF, 1'b1, 1'b0);
    build_expected();
    run(50, 1'b0, 1'b0);
    tot_n++;
    if (glog.size() > 4 && glog[0] === 4'b0000 && glog[1] === 4'b0001) pass_n++;
    else $display("FAIL single_grant got %b,%b required 0000,0001", glog[0], glog[1]);
    tot_n++;
    if (ocyc.size() == 3 && ocyc[0] == 2 && ocyc[1] == 3 && ocyc[2] == 4) pass_n++;
    else $display("FAIL single_timing got %0d beats first at %0d, required 3 beats at 2,3,4", ocyc.size(), ocyc.size() ? ocyc[0] : -1);
    tot_n++;
    if (blog.size() > 4 && blog[4] === 1'b0 && blog[3] === 1'b1) pass_n++;
    else $display("FAIL single_busy got %b after tlast, required 0", blog[4]);
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) add_beat(order[i], {32'hA0 + i, 32'h0}, 8'hFF, 1'b1, 1'b0);
    build_expected();
    run(50, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tot_n++;
      if (glog.size() > 2 + 2 * i && glog[1 + 2*i] === N'(1) << order[i] && glog[2 + 2*i] === '0) pass_n++;
      else $display("FAIL rr_grant %0d got %b then %b, required %b then 0000", i,
                    glog[1 + 2*i], glog[2 + 2*i], N'(1) << order[i]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    add_beat(2, 64'hC1C1C1C1C1C1C1C1, 8'hFF, 1'b0, 1'b0);
    add_beat(2, 64'hC2C2C2C2C2C2C2C2, 8'hFF, 1'b1, 1'b0);
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    build_expected();
    run(50, 1'b0, 1'b0);
    tot_n++;
    if (tlog.size() > 4 && tlog[1][2] === 1'b1 && tlog[2][2] === 1'b0 && tlog[3][2] === 1'b0 && tlog[4][2] === 1'b1) pass_n++;
    else $display("FAIL bp_ready got %b%b%b%b required 1001", tlog[1][2], tlog[2][2], tlog[3][2], tlog[4][2]);
    tot_n++;
    if (ocyc.size() == 2 && ocyc[0] == 4 && ocyc[1] == 5) pass_n++;
    else $display("FAIL bp_count got %0d beats, required 2 at cycles 4,5", ocyc.size());
  endtask

  task automatic test_user_keep();
    do_reset();
    add_beat(1, 64'hD1D1D1D1D1D1D1D1, 8'hFF, 1'b0, 1'b0);
    add_beat(1, 64'hD2D2D2D2D2D2D2D2, 8'h0F, 1'b1, 1'b1);
    build_expected();
    run(50, 1'b0, 1'b0);
    tot_n++;
    if (olog.size() == 2 && olog[1].k === 8'h0F && olog[1].u === 1'b1 && olog[1].l === 1'b1) pass_n++;
    else $display("FAIL user_keep got %0d beats, last keep/user/last = %h, required 0F/1/1",
                  olog.size(), olog.size() ? olog[olog.size()-1] : '0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_rand_msg(3, 3);
    run(2, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    tot_n++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, grant, busy, s_tready} === '0) pass_n++;
    else $display("FAIL reset_mid got v%b g%b b%b r%b d%h, required all 0", m_tvalid, grant, busy, s_tready, m_tdata);
    do_reset();
    add_beat(3, 64'h3333, 8'hFF, 1'b1, 1'b0);
    add_beat(0, 64'h0000, 8'hFF, 1'b1, 1'b0);
    build_expected();
    run(50, 1'b0, 1'b0);
    tot_n++;
    if (glog.size() > 1 && glog[1] === 4'b0001) pass_n++;
    else $display("FAIL reset_ptr got grant %b, required 0001", glog[1]);
  endtask

`ifdef ARB_BEAT_LIMIT_EN
  task automatic test_beat_limit();
    do_reset();
    add_rand_msg(0, 6);
    add_beat(1, 64'hB1, 8'hFF, 1'b1, 1'b0);
    add_beat(0, 64'hB0, 8'hFF, 1'b1, 1'b0);
    build_expected();
    run(100, 1'b0, 1'b0);
    tot_n++;
    if (olog.size() == 6 && olog[3].l === 1'b1 && olog[3].u === 1'b1 && olog[4].d === 64'hB1) pass_n++;
    else $display("FAIL beat_limit got %0d beats, required 6 with beat 4 last+user, then source 1", olog.size());
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) add_rand_msg($urandom_range(0, N - 1), $urandom_range(1, 6));
    build_expected();
    run(3000, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_user_keep();
    test_reset_mid();
`ifdef ARB_BEAT_LIMIT_EN
    test_beat_limit();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/msg_stream_arbiter.md
# msg_stream_arbiter

Packet-locked round-robin arbiter that shares the single message-assembly datapath between NUM_SRC AXI-Stream sources. It sits directly upstream of the message controller: it grants one source at a time, forwards that source's beats (tdata/tkeep/tlast/tuser) through one registered output stage, and releases the grant only after the beat carrying tlast. An optional beat limit truncates overlong messages and flags them as errors.

## Interface
- NUM_SRC, 4, number of requesting streams (2..8)
- DATA_BYTES, 8, bytes per beat
- TKEEP_WIDTH, 8, keep bits per beat (= DATA_BYTES)
- MAX_BEATS, 4, beat limit per message (MAX_MSG_BYTES/DATA_BYTES); used only with ARB_BEAT_LIMIT_EN

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready; at most one bit set
- s_tlast  in  NUM_SRC  per-source end of message
- s_tuser  in  NUM_SRC  per-source error flag
- s_tkeep  in  NUM_SRC*TKEEP_WIDTH  per-source keep, source k at [k*TKEEP_WIDTH +: TKEEP_WIDTH]
- s_tdata  in  NUM_SRC*8*DATA_BYTES  per-source data, source k at [k*8*DATA_BYTES +: 8*DATA_BYTES]
- m_tvalid  out  1  output beat valid
- m_tready  in  1  downstream ready
- m_tlast, m_tuser  out  1 each  forwarded flags
- m_tkeep  out  TKEEP_WIDTH  forwarded keep
- m_tdata  out  8*DATA_BYTES  forwarded data
- grant  out  NUM_SRC  one-hot current owner; 0 when idle
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, XFER, DRAIN (DRAIN exists only with ARB_BEAT_LIMIT_EN).
- IDLE: if any s_tvalid is set, select the first set bit at or after rr_ptr, searching upward with wrap; register grant; go to XFER. s_tready = 0 in IDLE.
- XFER: s_tready[g] = !m_tvalid || m_tready (the output register is free or draining this cycle). A beat is accepted when s_tvalid[g] && s_tready[g]. On each accepted beat, load the output register with the source fields and set m_tvalid. On an accepted beat with tlast: rr_ptr = (g+1) mod NUM_SRC, grant = 0, go to IDLE.
- Output register: m_tvalid clears on m_tready when no new beat is loaded in the same cycle. Simultaneous load and drain keeps m_tvalid = 1 with the new beat.
- Beat fields pass unmodified; tkeep is not interpreted.
- Non-granted sources see s_tready = 0 and must hold their beats.
- Reset: state = IDLE, rr_ptr = 0, grant = 0, busy = 0, all s_tready = 0, m_tvalid/m_tlast/m_tuser = 0, m_tkeep/m_tdata = 0. Reset mid-message drops the output beat and releases the grant; the source's remaining beats are then treated as a new message.

## Timing
- Request to grant: 1 cycle (request seen in IDLE at cycle N, grant and s_tready high at N+1).
- Beat accepted at cycle N appears on m_* at N+1.
- Sustained throughput: 1 beat/cycle while m_tready = 1.
- Message gap: 1 IDLE cycle between a tlast beat and the next grant.
- With m_tready = 0, at most one beat is held; s_tready drops the cycle after the register fills.

## Configuration
- ARB_BEAT_LIMIT_EN defined:
  - A beat counter counts accepted beats of the current message and resets on leaving XFER.
  - If beat number MAX_BEATS is accepted without tlast, it is output with m_tlast = 1 and m_tuser = 1, and the state goes to DRAIN.
  - DRAIN: s_tready[g] = 1 and accepted beats are discarded (nothing reaches m_*). On the accepted tlast beat, advance rr_ptr and go to IDLE.
- ARB_BEAT_LIMIT_EN undefined: no counter and no DRAIN state; messages are unbounded and MAX_BEATS is ignored.

## Test plan
- Single source 0 sends a 3-beat message (data 0x11.., 0x22.., 0x33.., tkeep 0xFF, tlast on beat 3) with m_tready = 1 -> grant = 0001 one cycle after valid; m_* shows the same three beats one cycle later, back-to-back, m_tlast on the third; then busy = 0.
- All 4 sources valid with 1-beat messages -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Source 2 sends 2 beats while m_tready toggles 1,0,0,1 -> no beat is lost or duplicated; s_tready[2] drops while the output register is full; the order is preserved.
- Source 1 sends a 2-beat message with tuser = 1 and tkeep = 0x0F on the last beat -> m_tuser = 1 and m_tkeep = 0x0F on the forwarded last beat.
- Reset asserted mid-message on source 3 (after beat 1) -> all outputs 0 immediately, grant = 0, rr_ptr = 0; after release with sources 0 and 3 valid, source 0 is granted first.
- ARB_BEAT_LIMIT_EN, MAX_BEATS = 4, source 0 sends 6 beats -> beats 1-4 are output, beat 4 with m_tlast = 1 and m_tuser = 1; beats 5-6 are consumed without output; rr_ptr = 1 afterwards.
